strike_tracker: RTL and testbench
=================================

Name: strike_tracker

Overview:
- Counts strike events raised by the puzzle modules and drives explode_strike into the game-over logic once the strike limit is reached.
- Also drives the strike count for the display and a stretched strike_flash pulse for the LED/buzzer.
- Sits between the puzzle modules and the game-over block; this is the producer side of the explode_strike signal.

Parameters:
- NUM_MODULES, 4, number of puzzle modules that can report strikes (1..8)
- MAX_STRIKES, 3, strike count at which explode_strike asserts (1..7)
- FLASH_CYCLES, 25000000, length of strike_flash in clock cycles (>=1)
- CNT_W, 3, width of strike_count; must hold MAX_STRIKES

Ports:
- clock  input  1  system clock; all logic on the rising edge
- reset  input  1  synchronous, active-low reset (0 = reset)
- strike_req  input  NUM_MODULES  per-module strike level; a strike is its 0->1 transition; may stay high any number of cycles
- game_over  input  1  sticky game-over from the game-over block; freezes counting
- strike_count  output  CNT_W  strikes taken, saturating at MAX_STRIKES
- explode_strike  output  1  high once strike_count == MAX_STRIKES; sticky
- strike_flash  output  1  high for FLASH_CYCLES after the most recent accepted strike
- state_dbg  output  2  current FSM state encoding, for debug LEDs

Behaviour:
- All outputs registered; no combinational input-to-output paths.
- Reset (reset==0 at a rising edge):
  - strike_count=0, explode_strike=0, strike_flash=0, flash counter=0, state=ARMED.
  - strike_prev loaded to all ones, so a line already high when reset releases is not counted until it drops and rises again.
- Edge detect: rise[i] = strike_req[i] & ~strike_prev[i]; strike_prev <= strike_req every non-reset cycle, in every state.
- Accepted strikes in a cycle: n = popcount(rise). Simultaneous rises from distinct modules each count.
- FSM states (state_dbg encoding):
  - ARMED (0): if game_over, go to HALTED and ignore that cycle's rises. Otherwise, if n>0:
    - strike_count <= min(strike_count + n, MAX_STRIKES); the sum is computed at CNT_W+1 bits before saturating.
    - Flash counter loads FLASH_CYCLES and strike_flash <= 1, in the same edge.
    - If the saturated result == MAX_STRIKES, explode_strike <= 1 in the same edge and go to EXPLODED.
  - EXPLODED (1): explode_strike held 1. strike_count frozen at MAX_STRIKES. Further rises ignored and do not retrigger the flash. Left only by reset.
  - HALTED (2): external game-over (e.g. timer expiry). strike_count frozen, explode_strike held 0, rises ignored. Left only by reset.
- Latency: a rise sampled at edge N is reflected in strike_count, explode_strike and strike_flash right after edge N, i.e. one cycle after the input change.
- Flash counter:
  - Decrements each cycle while nonzero; strike_flash = (counter != 0), registered.
  - A new accepted strike while the counter is nonzero reloads it to FLASH_CYCLES (retrigger).
  - A flash already running when entering EXPLODED or HALTED runs to completion.
- game_over and rise in the same cycle in ARMED: game_over wins; the strike is not counted.
- Reset mid-flash or in any state: returns to the reset values above on that edge.

Decomposition:
- Shared package (keep_talking_pkg):
  - FSM state encodings ARMED/EXPLODED/HALTED.
  - Default MAX_STRIKES and FLASH_CYCLES constants, reused by the display and timer blocks.
- One natural sub-module: pulse_stretch. It holds the retriggerable FLASH_CYCLES down-counter, with a trigger input and a level output, and is reusable for the other module-solved indicators.
- Edge detect, popcount and FSM stay in strike_tracker.

Test Plan (bench parameters FLASH_CYCLES=4, NUM_MODULES=4, MAX_STRIKES=3):
- Reset release with strike_req=4'b0010 held high -> strike_count stays 0. Then drop bit1 for 1 cycle and raise it -> strike_count=1 one cycle later, strike_flash high exactly 4 cycles.
- Three separate single-cycle rises on module 0, 10 cycles apart -> strike_count 1,2,3. explode_strike rises on the same edge count becomes 3 and stays high for 20 more cycles; state_dbg=1.
- strike_count=1, then strike_req 0000->1111 in one cycle -> strike_count=3 (saturated, not 5), explode_strike=1 on that edge.
- Rise at cycle 0 and another at cycle 2 -> strike_flash continuously high from cycle 1 through cycle 6 (retrigger), low at cycle 7.
- strike_count=2, game_over=1 in the same cycle as a rise -> strike_count stays 2, explode_strike=0, state_dbg=2. Later rises ignored.
- In EXPLODED, drive reset=0 for 1 cycle -> all outputs 0, state_dbg=0. A new rise afterwards yields strike_count=1.

Source files
------------

// File: rtl/keep_talking_pkg.sv
// Shared definitions for the bomb-game blocks: strike FSM encodings, default
// limits and a small popcount helper.
package keep_talking_pkg;

    typedef enum logic [1:0] {
        ARMED    = 2'd0,
        EXPLODED = 2'd1,
        HALTED   = 2'd2
    } state_t;

    localparam int MAX_STRIKES_DEF  = 3;
    localparam int FLASH_CYCLES_DEF = 25000000;

    function automatic logic [3:0] popcount8(input logic [7:0] v);
        logic [3:0] c;
        c = 4'd0;
        for (int i = 0; i < 8; i++) begin
            c = c + {3'd0, v[i]};
        end
        return c;
    endfunction

endpackage

// File: rtl/pulse_stretch.sv
// Retriggerable pulse stretcher: a trigger loads CYCLES into a down-counter and
// the registered level output stays high while the counter is nonzero.
module pulse_stretch #(
    parameter int CYCLES = 25000000,
    parameter int CW     = $clog2(CYCLES + 1)
) (
    input  logic clock_i,
    input  logic reset_i,
    input  logic trig_i,
    output logic pulse_o
);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic          pulse_q;

    // Next count: reload on trigger, otherwise count down to zero and hold.
    always_comb begin
        cnt_d = cnt_q;
        if (trig_i) begin
            cnt_d = CW'(CYCLES);
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - CW'(1);
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Counter and output register, synchronous active-low reset.
    always_ff @(posedge clock_i) begin
        if (!reset_i) begin
            cnt_q   <= '0;
            pulse_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            pulse_q <= (cnt_d != '0);
        end
    end

    assign pulse_o = pulse_q;

endmodule

// File: rtl/strike_tracker.sv
// Counts rising-edge strikes from the puzzle modules, saturates at MAX_STRIKES
// and raises a sticky explode_strike; game_over freezes the tracker.
module strike_tracker
    import keep_talking_pkg::*;
#(
    parameter int NUM_MODULES  = 4,
    parameter int MAX_STRIKES  = MAX_STRIKES_DEF,
    parameter int FLASH_CYCLES = FLASH_CYCLES_DEF,
    parameter int CNT_W        = 3
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [NUM_MODULES-1:0] strike_req,
    input  logic                   game_over,
    output logic [CNT_W-1:0]       strike_count,
    output logic                   explode_strike,
    output logic                   strike_flash,
    output logic [1:0]             state_dbg
);

    // Wide enough for count + up to eight simultaneous strikes without wrapping.
    localparam int SUM_W = (CNT_W + 1 > 4) ? CNT_W + 1 : 4;

    state_t                 state_q;
    logic [NUM_MODULES-1:0] prev_q;
    logic [CNT_W-1:0]       count_q;
    logic                   explode_q;

    logic [NUM_MODULES-1:0] rise_s;
    logic [3:0]             n_s;
    logic [SUM_W-1:0]       sum_s;
    logic [CNT_W-1:0]       sat_s;
    logic                   accept_s;

    // Edge detect, strike popcount and saturating next count.
    always_comb begin
        rise_s = strike_req & ~prev_q;
        n_s    = popcount8(8'(rise_s));
        sum_s  = SUM_W'(count_q) + SUM_W'(n_s);
        if (sum_s >= SUM_W'(MAX_STRIKES)) begin
            sat_s = CNT_W'(MAX_STRIKES);
        end else begin
            sat_s = sum_s[CNT_W-1:0];
        end
        accept_s = (state_q == ARMED) && !game_over && (n_s != 4'd0);
    end

    // Strike FSM with registered count and explode outputs.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q   <= ARMED;
            prev_q    <= '1;
            count_q   <= '0;
            explode_q <= 1'b0;
        end else begin
            prev_q <= strike_req;
            case (state_q)
                ARMED: begin
                    if (game_over) begin
                        state_q <= HALTED;
                    end else if (accept_s) begin
                        count_q <= sat_s;
                        if (sat_s == CNT_W'(MAX_STRIKES)) begin
                            explode_q <= 1'b1;
                            state_q   <= EXPLODED;
                        end else begin
                            state_q <= ARMED;
                        end
                    end else begin
                        state_q <= ARMED;
                    end
                end
                EXPLODED: begin
                    explode_q <= 1'b1;
                    state_q   <= EXPLODED;
                end
                HALTED: begin
                    explode_q <= 1'b0;
                    state_q   <= HALTED;
                end
                default: begin
                    state_q   <= ARMED;
                    explode_q <= 1'b0;
                end
            endcase
        end
    end

    pulse_stretch #(
        .CYCLES (FLASH_CYCLES)
    ) u_flash (
        .clock_i (clock),
        .reset_i (reset),
        .trig_i  (accept_s),
        .pulse_o (strike_flash)
    );

    assign strike_count   = count_q;
    assign explode_strike = explode_q;
    assign state_dbg      = state_q;

endmodule

// File: tb/tb_strike_tracker.sv
// Scoreboard bench for strike_tracker: a behavioural model queues the expected
// outputs for each driven cycle and each test pops and compares after the edge.
module tb_strike_tracker;

    logic       clock;
    logic       reset;
    logic [3:0] strike_req;
    logic       game_over;
    logic [2:0] strike_count;
    logic       explode_strike;
    logic       strike_flash;
    logic [1:0] state_dbg;

    int total = 0;
    int bad   = 0;

    logic [6:0] sb[$];
    logic [6:0] e;
    wire  [6:0] got = {state_dbg, explode_strike, strike_flash, strike_count};

    // Reference model state
    logic [3:0] m_prev;
    int         m_cnt, m_exp, m_fc, m_state;

    strike_tracker #(
        .NUM_MODULES (4),
        .MAX_STRIKES (3),
        .FLASH_CYCLES(4),
        .CNT_W       (3)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .strike_req    (strike_req),
        .game_over     (game_over),
        .strike_count  (strike_count),
        .explode_strike(explode_strike),
        .strike_flash  (strike_flash),
        .state_dbg     (state_dbg)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    // Drive one cycle of inputs and push the model's expected post-edge outputs.
    task automatic drive(input logic [3:0] req, input logic go, input logic rst_n);
        logic [3:0] rise;
        int n;
        bit trig;
        strike_req = req;
        game_over  = go;
        reset      = rst_n;
        trig = 0;
        if (!rst_n) begin
            m_prev = 4'hF; m_cnt = 0; m_exp = 0; m_fc = 0; m_state = 0;
        end else begin
            rise   = req & ~m_prev;
            m_prev = req;
            n      = $countones(rise);
            if (m_state == 0) begin
                if (go) m_state = 2;
                else if (n > 0) begin
                    m_cnt = (m_cnt + n > 3) ? 3 : m_cnt + n;
                    trig  = 1;
                    if (m_cnt == 3) begin
                        m_exp   = 1;
                        m_state = 1;
                    end
                end
            end
            if (trig) m_fc = 4;
            else if (m_fc > 0) m_fc = m_fc - 1;
        end
        sb.push_back({2'(m_state), 1'(m_exp), (m_fc != 0), 3'(m_cnt)});
    endtask

    // stim word: {rst_n, game_over, strike_req[3:0]}
    task automatic test_reset;
        logic [5:0] st[$];
        st = '{6'b0_0_0010, 6'b1_0_0010, 6'b1_0_0010, 6'b1_0_0010, 6'b1_0_0000,
               6'b1_0_0010, 6'b1_0_0010, 6'b1_0_0010, 6'b1_0_0010, 6'b1_0_0010,
               6'b1_0_0010};
        foreach (st[i]) begin
            drive(st[i][3:0], st[i][4], st[i][5]);
            @(posedge clock); #1;
            e = sb.pop_front();
            total++;
            if (got !== e) begin
                bad++;
                $display("FAIL reset[%0d] got=%b exp=%b", i, got, e);
            end
        end
        total++;
        if (strike_count !== 3'd1 || strike_flash !== 1'b0) begin
            bad++;
            $display("FAIL reset_final got cnt=%0d flash=%b exp cnt=1 flash=0",
                     strike_count, strike_flash);
        end
    endtask

    task automatic test_three_strikes;
        logic [5:0] st[$];
        st = '{6'b0_0_0000, 6'b1_0_0000};
        for (int k = 0; k < 3; k++) begin
            st.push_back(6'b1_0_0001);
            for (int j = 0; j < 9; j++) st.push_back(6'b1_0_0000);
        end
        for (int j = 0; j < 20; j++) st.push_back(6'b1_0_0000);
        foreach (st[i]) begin
            drive(st[i][3:0], st[i][4], st[i][5]);
            @(posedge clock); #1;
            e = sb.pop_front();
            total++;
            if (got !== e) begin
                bad++;
                $display("FAIL three[%0d] got=%b exp=%b", i, got, e);
            end
        end
        total++;
        if (strike_count !== 3'd3 || explode_strike !== 1'b1 || state_dbg !== 2'd1) begin
            bad++;
            $display("FAIL three_final got cnt=%0d exp=%b st=%0d need 3 1 1",
                     strike_count, explode_strike, state_dbg);
        end
    endtask

    task automatic test_saturate;
        logic [5:0] st[$];
        st = '{6'b0_0_0000, 6'b1_0_0000, 6'b1_0_0001, 6'b1_0_0000, 6'b1_0_1111,
               6'b1_0_0000, 6'b1_0_0000};
        foreach (st[i]) begin
            drive(st[i][3:0], st[i][4], st[i][5]);
            @(posedge clock); #1;
            e = sb.pop_front();
            total++;
            if (got !== e) begin
                bad++;
                $display("FAIL saturate[%0d] got=%b exp=%b", i, got, e);
            end
        end
        total++;
        if (strike_count !== 3'd3 || explode_strike !== 1'b1) begin
            bad++;
            $display("FAIL saturate_final got cnt=%0d exp=%b need 3 1",
                     strike_count, explode_strike);
        end
    endtask

    task automatic test_retrigger;
        logic [5:0] st[$];
        st = '{6'b0_0_0000, 6'b1_0_0000, 6'b1_0_0001, 6'b1_0_0000, 6'b1_0_0010,
               6'b1_0_0000, 6'b1_0_0000, 6'b1_0_0000, 6'b1_0_0000, 6'b1_0_0000,
               6'b1_0_0000};
        foreach (st[i]) begin
            drive(st[i][3:0], st[i][4], st[i][5]);
            @(posedge clock); #1;
            e = sb.pop_front();
            total++;
            if (got !== e) begin
                bad++;
                $display("FAIL retrigger[%0d] got=%b exp=%b", i, got, e);
            end
        end
    endtask

    task automatic test_game_over;
        logic [5:0] st[$];
        st = '{6'b0_0_0000, 6'b1_0_0000, 6'b1_0_0001, 6'b1_0_0000, 6'b1_0_0010,
               6'b1_0_0000, 6'b1_1_0100, 6'b1_1_0000, 6'b1_1_1000, 6'b1_1_0000,
               6'b1_1_1111, 6'b1_1_0000};
        foreach (st[i]) begin
            drive(st[i][3:0], st[i][4], st[i][5]);
            @(posedge clock); #1;
            e = sb.pop_front();
            total++;
            if (got !== e) begin
                bad++;
                $display("FAIL game_over[%0d] got=%b exp=%b", i, got, e);
            end
        end
        total++;
        if (strike_count !== 3'd2 || explode_strike !== 1'b0 || state_dbg !== 2'd2) begin
            bad++;
            $display("FAIL game_over_final got cnt=%0d exp=%b st=%0d need 2 0 2",
                     strike_count, explode_strike, state_dbg);
        end
    endtask

    task automatic test_reset_exploded;
        logic [5:0] st[$];
        st = '{6'b0_0_0000, 6'b1_0_0000, 6'b1_0_0111, 6'b1_0_0000, 6'b1_0_0000,
               6'b0_0_0000, 6'b1_0_0000, 6'b1_0_0001, 6'b1_0_0000};
        foreach (st[i]) begin
            drive(st[i][3:0], st[i][4], st[i][5]);
            @(posedge clock); #1;
            e = sb.pop_front();
            total++;
            if (got !== e) begin
                bad++;
                $display("FAIL reset_exploded[%0d] got=%b exp=%b", i, got, e);
            end
        end
        total++;
        if (strike_count !== 3'd1 || explode_strike !== 1'b0 || state_dbg !== 2'd0) begin
            bad++;
            $display("FAIL reset_exploded_final got cnt=%0d exp=%b st=%0d need 1 0 0",
                     strike_count, explode_strike, state_dbg);
        end
    endtask

    task automatic test_random;
        logic [3:0] req;
        logic       go;
        logic       rn;
        for (int i = 0; i < 400; i++) begin
            rn  = ($urandom_range(0, 39) != 0);
            go  = ($urandom_range(0, 49) == 0);
            req = 4'($urandom_range(0, 15));
            drive(req, go, rn);
            @(posedge clock); #1;
            e = sb.pop_front();
            total++;
            if (got !== e) begin
                bad++;
                $display("FAIL random[%0d] got=%b exp=%b", i, got, e);
            end
        end
    endtask

    initial begin
        reset      = 1'b0;
        strike_req = 4'b0000;
        game_over  = 1'b0;
        test_reset();
        test_three_strikes();
        test_saturate();
        test_retrigger();
        test_game_over();
        test_reset_exploded();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
